// File: rtl/cond_invert_pipe_if.sv
// cond_invert_pipe_if: bundles the cond_invert_pipe data-path signals.
//   Upstream  : in_valid, in_ready, in_data[WIDTH], in_mode[2]
//   Downstream: out_valid, out_ready, out_data[WIDTH], out_ovf
//   Status    : level[clog2(DEPTH+1)], ovf_count[8]
// The master modport is the environment side. The slave modport is the block side.
interface cond_invert_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic [LW-1:0]    level;
    logic [7:0]       ovf_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, level, ovf_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, level, ovf_count
    );
endinterface

// File: rtl/cond_invert_pipe.sv
// cond_invert_pipe: applies a per-word operation to each accepted word.
// The operation is pass, invert, negate or absolute value.
// Each result and its overflow flag go into a DEPTH-entry FIFO.
//   clk   : single rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : cond_invert_pipe_if.slave, which carries the in/out handshakes and the status outputs
module cond_invert_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic               clk,
    input logic               rst_n,
    cond_invert_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] ovf_mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             in_ready_q, in_ready_d;
    logic [7:0]       cnt_q;

    logic [WIDTH-1:0] res;
    logic             res_ovf;
    logic             push, pop, out_valid;

    // Result computation. Negating the most negative value wraps back to the same value.
    // That case is reported as overflow.
    always_comb begin
        res     = bus.in_data;
        res_ovf = 1'b0;
        case (bus.in_mode)
            2'b00: res = bus.in_data;
            2'b01: res = ~bus.in_data;
            2'b10: begin
                res     = ~bus.in_data + ONE;
                res_ovf = (bus.in_data == MOST_NEG);
            end
            default: begin
                res     = bus.in_data[WIDTH-1] ? (~bus.in_data + ONE) : bus.in_data;
                res_ovf = (bus.in_data == MOST_NEG);
            end
        endcase
    end

    assign out_valid = (level_q != '0);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // in_ready is registered from the next level.
    // This keeps out_ready out of any combinational path to in_ready.
    // It also holds in_ready low during reset and for the first edge after release.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        in_ready_d = (level_d < LW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ovf_mem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]     <= res;
                ovf_mem_q[wr_ptr_q] <= res_ovf;
                wr_ptr_q            <= wr_ptr_q + AW'(1);
                if (res_ovf && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.out_ovf   = out_valid & ovf_mem_q[rd_ptr_q];
    assign bus.level     = level_q;
    assign bus.ovf_count = cnt_q;
endmodule
